// File: rtl/sample_xfer_sched_pkg.sv
// rtl/sample_xfer_sched_pkg.sv - shared constants and state encoding for the sample readout scheduler
package sample_xfer_sched_pkg;

    localparam int NCH         = 16;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_READ    = 3'd2,
        ST_NEXT_CH = 3'd3,
        ST_STALL   = 3'd4,
        ST_DONE    = 3'd5
    } xstate_t;

endpackage

// File: rtl/sample_xfer_sched_evt_cnt.sv
// rtl/sample_xfer_sched_evt_cnt.sv - saturating pending-event counter with sticky overflow
module xfer_evt_cnt #(
    parameter int PEND_W = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              clr,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] cnt,
    output logic              ovfl
);

    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    // Simultaneous inc and dec cancel; clr leaves the sticky flag alone.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt  <= '0;
            ovfl <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            if (cnt == CNT_MAX) begin
                ovfl <= 1'b1;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end else if (dec && !inc && cnt != '0) begin
            cnt <= cnt - CNT_ONE;
        end
    end

endmodule

// File: rtl/sample_xfer_sched.sv
// rtl/sample_xfer_sched.sv - walks channels 0..15 reading NSAMP samples each per queued event
module sample_xfer_sched
    import sample_xfer_sched_pkg::*;
#(
    parameter int SAMP_W  = 7,
    parameter int PEND_W  = 4,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              JTAG_MODE,
    input  logic              RDY,
    input  logic [15:0]       F16_MT,
    input  logic              RB_FULL,
    input  logic [SAMP_W-1:0] NSAMP,
    output logic [3:0]        CHAN,
    output logic              RDENA,
    output logic              L1A_RD_EN,
    output logic [2:0]        XSTATE,
    output logic              BUSY,
    output logic [PEND_W-1:0] PEND,
    output logic              OVFL,
    output logic              UFLOW_ERR
);

    localparam int                  STALL_W    = $clog2(TIMEOUT + 1);
    localparam logic [STALL_W-1:0]  STALL_LAST = STALL_W'(TIMEOUT - 1);
    localparam logic [STALL_W-1:0]  STALL_ONE  = STALL_W'(1);
    localparam logic [SAMP_W-1:0]   SAMP_ONE   = SAMP_W'(1);
    localparam logic [3:0]          LAST_CH    = 4'(NCH - 1);

    xstate_t            state_q, state_d;
    logic [3:0]         chan_q;
    logic [SAMP_W-1:0]  nsamp_q, cnt_q, last_samp;
    logic [STALL_W-1:0] stall_q;
    logic               l1a_q, uflow_q;
    logic               mt_cur, avail, rdena_c, pend_dec, tmo;

    assign mt_cur    = F16_MT[chan_q];
    assign avail     = !mt_cur && !RB_FULL;
    assign last_samp = nsamp_q - SAMP_ONE;

    always_comb begin
        state_d  = state_q;
        rdena_c  = 1'b0;
        pend_dec = 1'b0;
        tmo      = 1'b0;
        case (state_q)
            ST_IDLE:    if (PEND != '0) state_d = ST_START;
            ST_START:   state_d = (nsamp_q == '0) ? ST_DONE : ST_READ;
            ST_READ: begin
                rdena_c = avail;
                if (!avail) begin
                    state_d = ST_STALL;
                end else if (cnt_q == last_samp) begin
                    state_d = (chan_q == LAST_CH) ? ST_DONE : ST_NEXT_CH;
                end
            end
            ST_NEXT_CH: state_d = ST_READ;
            ST_STALL: begin
                if (avail) begin
                    state_d = ST_READ;
                end else if (!RB_FULL && stall_q == STALL_LAST) begin
                    tmo     = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                pend_dec = 1'b1;
                state_d  = ST_IDLE;
            end
            default:    state_d = ST_IDLE;
        endcase
        // JTAG ownership gates the read strobe immediately and parks the FSM next clock.
        if (JTAG_MODE) begin
            state_d = ST_IDLE;
            rdena_c = 1'b0;
            tmo     = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            chan_q  <= '0;
            nsamp_q <= '0;
            cnt_q   <= '0;
            stall_q <= '0;
            l1a_q   <= 1'b0;
            uflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            l1a_q   <= (state_d == ST_START);
            if (tmo) uflow_q <= 1'b1;
            // Only RB_FULL-free empty cycles in STALL accumulate toward the timeout.
            stall_q <= (state_q == ST_STALL && !RB_FULL && mt_cur) ? stall_q + STALL_ONE : '0;
            if (state_d == ST_START) begin
                nsamp_q <= NSAMP;
                chan_q  <= '0;
                cnt_q   <= '0;
            end else if (state_q == ST_NEXT_CH) begin
                chan_q <= chan_q + 4'd1;
                cnt_q  <= '0;
            end else if (rdena_c) begin
                cnt_q <= cnt_q + SAMP_ONE;
            end
        end
    end

    xfer_evt_cnt #(.PEND_W(PEND_W)) u_evt_cnt (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (JTAG_MODE),
        .inc  (RDY),
        .dec  (pend_dec),
        .cnt  (PEND),
        .ovfl (OVFL)
    );

    assign CHAN      = chan_q;
    assign RDENA     = rdena_c;
    assign L1A_RD_EN = l1a_q;
    assign XSTATE    = state_q;
    assign BUSY      = (state_q != ST_IDLE);
    assign UFLOW_ERR = uflow_q;

endmodule

// File: tb/tb_sample_xfer_sched.sv
// tb/tb_sample_xfer_sched.sv - self-checking bench for sample_xfer_sched
module tb_sample_xfer_sched;

    localparam int SAMP_W = 7;
    localparam int PEND_W = 4;

    logic              CLK = 1'b0;
    logic              RST, JTAG_MODE, RDY, RB_FULL;
    logic [15:0]       F16_MT;
    logic [SAMP_W-1:0] NSAMP;
    logic [3:0]        CHAN;
    logic              RDENA, L1A_RD_EN, BUSY, OVFL, UFLOW_ERR;
    logic [2:0]        XSTATE;
    logic [PEND_W-1:0] PEND;

    int total = 0;
    int bad   = 0;

    sample_xfer_sched #(.SAMP_W(SAMP_W), .PEND_W(PEND_W), .TIMEOUT(255)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .JTAG_MODE (JTAG_MODE),
        .RDY       (RDY),
        .F16_MT    (F16_MT),
        .RB_FULL   (RB_FULL),
        .NSAMP     (NSAMP),
        .CHAN      (CHAN),
        .RDENA     (RDENA),
        .L1A_RD_EN (L1A_RD_EN),
        .XSTATE    (XSTATE),
        .BUSY      (BUSY),
        .PEND      (PEND),
        .OVFL      (OVFL),
        .UFLOW_ERR (UFLOW_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int nsamp;
        int ch;
        bit rbf;
        int w0;
        int w1;
        int exp_busy;
        int exp_rd;
        int exp_chan;
        bit exp_uflow;
    } row_t;

    row_t rows[5];
    int   busy_n, rd_n, l1a_n, chan_done;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_xstate"}, 32'(XSTATE), 0);
        chk({tag, "_chan"},   32'(CHAN), 0);
        chk({tag, "_rdena"},  32'(RDENA), 0);
        chk({tag, "_l1a"},    32'(L1A_RD_EN), 0);
        chk({tag, "_busy"},   32'(BUSY), 0);
        chk({tag, "_pend"},   32'(PEND), 0);
        chk({tag, "_ovfl"},   32'(OVFL), 0);
        chk({tag, "_uflow"},  32'(UFLOW_ERR), 0);
    endtask

    // Cycle i=0 carries RDY, so START (event time t=0) is cycle i=2.
    task automatic run_row(input row_t r, output int busy, output int rd, output int l1a,
                           output int chan_d);
        busy = 0; rd = 0; l1a = 0; chan_d = -1;
        NSAMP = SAMP_W'(r.nsamp);
        for (int i = 0; i < 3000; i++) begin
            int t;
            t = i - 2;
            @(posedge CLK); #1;
            RDY     = (i == 0);
            F16_MT  = '0;
            RB_FULL = 1'b0;
            if (t >= r.w0 && t < r.w1) begin
                if (r.rbf) RB_FULL = 1'b1;
                else       F16_MT[r.ch] = 1'b1;
            end
            @(negedge CLK);
            if (BUSY)      busy++;
            if (RDENA)     rd++;
            if (L1A_RD_EN) l1a++;
            if (XSTATE == 3'd5) chan_d = int'(CHAN);
            if (i >= 2 && !BUSY) break;
        end
        F16_MT  = '0;
        RB_FULL = 1'b0;
    endtask

    initial begin
        RST = 1'b1; JTAG_MODE = 1'b0; RDY = 1'b0; RB_FULL = 1'b0;
        F16_MT = '0; NSAMP = '0;

        rows[0] = '{8, 0,  1'b0, 0,  0,      145, 128, 15, 1'b0};
        rows[1] = '{4, 3,  1'b0, 0,  36,     102, 64,  15, 1'b0};
        rows[2] = '{0, 0,  1'b0, 0,  0,      2,   0,   0,  1'b0};
        rows[3] = '{1, 15, 1'b1, 31, 331,    334, 16,  15, 1'b0};
        rows[4] = '{3, 5,  1'b0, 0,  100000, 278, 15,  5,  1'b1};

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk_reset_outputs("rst");
        RST = 1'b0;

        for (int r = 0; r < 5; r++) begin
            run_row(rows[r], busy_n, rd_n, l1a_n, chan_done);
            chk($sformatf("row%0d_busy", r),  32'(busy_n), 32'(rows[r].exp_busy));
            chk($sformatf("row%0d_rdena", r), 32'(rd_n), 32'(rows[r].exp_rd));
            chk($sformatf("row%0d_l1a", r),   32'(l1a_n), 1);
            chk($sformatf("row%0d_chan", r),  32'(chan_done), 32'(rows[r].exp_chan));
            chk($sformatf("row%0d_uflow", r), 32'(UFLOW_ERR), 32'(rows[r].exp_uflow));
            chk($sformatf("row%0d_pend", r),  32'(PEND), 0);
        end

        // RDY landing in the DONE cycle: PEND must stay put.
        NSAMP = 7'd2;
        for (int i = 0; i <= 51; i++) begin
            @(posedge CLK); #1;
            RDY = (i == 0 || i == 50);
            @(negedge CLK);
            if (i == 50) begin
                chk("coin_done_state", 32'(XSTATE), 5);
                chk("coin_pend_before", 32'(PEND), 1);
            end
        end
        chk("coin_pend_after", 32'(PEND), 1);
        chk("coin_idle_after", 32'(XSTATE), 0);
        RDY = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge CLK);
            if (!BUSY && PEND == '0) break;
        end
        chk("coin_drained", 32'(!BUSY && PEND == '0), 1);

        // Saturation, then JTAG takeover while reading channel 7.
        NSAMP = 7'd20;
        for (int i = 0; i <= 159; i++) begin
            @(posedge CLK); #1;
            RDY       = (i < 17);
            JTAG_MODE = (i >= 155 && i <= 157);
            @(negedge CLK);
            if (i == 14) begin
                chk("sat_pend14", 32'(PEND), 14);
                chk("sat_ovfl_early", 32'(OVFL), 0);
            end
            if (i == 17) begin
                chk("sat_pend", 32'(PEND), 15);
                chk("sat_ovfl", 32'(OVFL), 1);
            end
            if (i == 154) begin
                chk("jtag_pre_rdena", 32'(RDENA), 1);
                chk("jtag_pre_chan", 32'(CHAN), 7);
            end
            if (i == 155) begin
                chk("jtag_rdena_gate", 32'(RDENA), 0);
                chk("jtag_still_read", 32'(XSTATE), 2);
            end
            if (i == 156) begin
                chk("jtag_idle", 32'(XSTATE), 0);
                chk("jtag_pend_clr", 32'(PEND), 0);
                chk("jtag_busy", 32'(BUSY), 0);
                chk("jtag_ovfl_held", 32'(OVFL), 1);
                chk("jtag_uflow_held", 32'(UFLOW_ERR), 1);
            end
            if (i == 157) chk("jtag_no_start", 32'(L1A_RD_EN), 0);
            if (i == 159) chk("jtag_release_idle", 32'(XSTATE), 0);
        end

        // Asynchronous reset in the middle of an event.
        NSAMP = 7'd3;
        for (int i = 0; i <= 12; i++) begin
            @(posedge CLK); #1;
            RDY = (i == 0);
            @(negedge CLK);
        end
        chk("mid_busy", 32'(BUSY), 1);
        chk("mid_chan", 32'(CHAN), 2);
        @(posedge CLK); #3;
        RST = 1'b1;
        #1;
        chk_reset_outputs("arst");
        @(negedge CLK);
        RST = 1'b0;

        // Randomized batches; a read k of an event must come from channel k/NSAMP.
        for (int b = 0; b < 4; b++) begin
            int n, k, issued, starts, reads, ridx, order_bad;
            n = int'($urandom_range(1, 5));
            k = int'($urandom_range(2, 6));
            NSAMP = SAMP_W'(n);
            issued = 0; starts = 0; reads = 0; ridx = 0; order_bad = 0;
            for (int cyc = 0; cyc < 20000; cyc++) begin
                @(posedge CLK); #1;
                RDY = (issued < k) && ($urandom_range(0, 39) == 0);
                if (RDY) issued++;
                for (int c = 0; c < 16; c++) F16_MT[c] = ($urandom_range(0, 7) == 0);
                RB_FULL = ($urandom_range(0, 3) == 0);
                @(negedge CLK);
                if (L1A_RD_EN) begin
                    starts++;
                    ridx = 0;
                end
                if (RDENA) begin
                    if (int'(CHAN) != ridx / n || F16_MT[CHAN] || RB_FULL) begin
                        if (order_bad == 0)
                            $display("FAIL rand%0d_read: chan=%0d mt=%0b rbf=%0b want chan %0d",
                                     b, CHAN, F16_MT[CHAN], RB_FULL, ridx / n);
                        order_bad++;
                    end
                    ridx++;
                    reads++;
                end
                if (issued == k && !RDY && !BUSY && PEND == '0) break;
            end
            RDY = 1'b0;
            chk($sformatf("rand%0d_idle", b),   32'(BUSY), 0);
            chk($sformatf("rand%0d_starts", b), 32'(starts), 32'(k));
            chk($sformatf("rand%0d_reads", b),  32'(reads), 32'(k * 16 * n));
            chk($sformatf("rand%0d_order", b),  32'(order_bad), 0);
        end
        chk("rand_uflow", 32'(UFLOW_ERR), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
